ahb_arbiter_rr: RTL and testbench
=================================

# ahb_arbiter_rr

Round-robin AHB bus arbiter for the multi-master AHB interconnect (3 masters, 2 slaves as built).
- Samples the master bus requests and the lock requests, and drives the per-master grants, the HMASTER address-mux select and HMASTLOCK.
- Never breaks a fixed-length burst or a locked sequence.
- Optionally masks SPLIT-responded masters until the slave releases them.

## Interface
- P_NUMM, 3, number of masters (1..16).
- P_DEFAULT_MST, 0, master granted when nobody requests; also the reset owner.
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- HBUSREQ  in  P_NUMM  per-master bus request.
- HLOCK  in  P_NUMM  per-master lock request.
- HTRANS  in  2  transfer type of the current address-phase owner (muxed by HMASTER).
- HBURST  in  3  burst type of the current owner.
- HREADY  in  1  bus-wide ready.
- HRESP  in  2  bus-wide response.
- HSPLIT  in  16  OR of all slave HSPLIT vectors; bit i releases master i.
- HGRANT  out  P_NUMM  one-hot grant, registered.
- HMASTER  out  4  index of the address-phase owner, registered.
- HMASTLOCK  out  1  owner's transfer is locked, registered.

## Operation
- Reset values:
  - HGRANT = one-hot(P_DEFAULT_MST); HMASTER = P_DEFAULT_MST; HMASTLOCK = 0.
  - Round-robin pointer = P_DEFAULT_MST; beat counter = 0; split mask = 0; state = ARB.
- Beat counter, 5 bits, updated only on edges with HREADY=1:
  - NONSEQ loads len-1, where len is 4/8/16 for (INCR|WRAP)4/8/16, and 0 for SINGLE/INCR.
  - SEQ decrements if nonzero.
  - BUSY and IDLE hold the counter.
- State ARB, arbitration permitted.
  - Go to BURST on NONSEQ of a fixed burst.
  - Go to LOCK when HLOCK[granted] is set.
- State BURST, grant frozen.
  - Leave on the HREADY edge that accepts the last beat (SEQ with counter==1); that edge is an arbitration edge.
- State LOCK, grant frozen while HLOCK[granted]=1.
  - On HLOCK deassertion, the next HREADY edge is an arbitration edge.
- Arbitration edge: HREADY=1 in ARB, or an exit edge from BURST/LOCK.
  - Candidate set = HBUSREQ & ~split_mask.
  - Winner = first candidate searching pointer+1, pointer+2, …, modulo P_NUMM.
  - If the candidate set is empty, winner = P_DEFAULT_MST.
  - HGRANT <= one-hot(winner); pointer <= winner.
  - A currently granted master that still requests loses only if another candidate exists.
- Ownership handover: every HREADY edge, HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)].
- Error abort: HRESP ERROR, RETRY or SPLIT seen with HREADY=0 clears the counter and forces ARB. The following HREADY edge (second response cycle) is an arbitration edge.
- A RETRY'd master stays a candidate.

## Timing
- Request to grant: 1 cycle after the sampling arbitration edge.
- Grant to HMASTER: next HREADY=1 edge after the HGRANT change. The old owner drives IDLE in that interval.
- Uncontended single transfers from one master: grant held, zero handover cycles.
- HREADY=0 freezes HGRANT, HMASTER, HMASTLOCK and the counter (except the error abort).
- Simultaneous release and new SPLIT for the same master in one cycle: the mask bit stays set (SPLIT wins).
- Reset asserted mid-burst: all outputs return to reset values on that edge; the counter clears.

## Configuration
- AHB_ARB_SPLIT_EN defined:
  - SPLIT with HREADY=0 sets split_mask[HMASTER].
  - HSPLIT[i]=1 clears split_mask[i] on the next edge.
  - Masked masters are never granted, except P_DEFAULT_MST when all candidates are empty.
- AHB_ARB_SPLIT_EN undefined:
  - split_mask is tied to 0 and HSPLIT is ignored.
  - SPLIT behaves exactly like RETRY.

## Structure
- Package ahb_arb_pkg:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HBURST codes.
  - HRESP codes (OKAY/ERROR/RETRY/SPLIT).
  - Burst-length function returning 0/4/8/16.
- Sub-module ahb_rr_pick: combinational rotate-and-priority-encode.
  - Inputs: request vector, pointer.
  - Outputs: winner index, valid.

## Test plan
- Reset, then masters 0 and 2 request simultaneously with pointer 0 → HGRANT=3'b100 after 1 cycle; after master 2 finishes, HGRANT=3'b001.
- Master 1 INCR8 while master 0 requests throughout → HGRANT stays 3'b010 for all 8 beats; changes to 3'b001 on the edge accepting beat 8.
- Master 0 holds HLOCK across 3 SINGLE transfers while master 1 requests → HMASTLOCK=1, HGRANT=3'b001 until HLOCK drops; then 3'b010.
- With AHB_ARB_SPLIT_EN, slave returns SPLIT to master 2 → master 2 is not granted despite HBUSREQ=1; after HSPLIT[2]=1 it wins the next arbitration.
- No requests → HGRANT=one-hot(P_DEFAULT_MST), HMASTER=P_DEFAULT_MST; HREADY held low 5 cycles during a request change → outputs unchanged.
- Reset asserted at beat 3 of WRAP4 → next edge HGRANT=one-hot(0), HMASTER=0, HMASTLOCK=0; the following burst arbitrates normally.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings, arbiter state type and the burst-length helper
// used by the round-robin AHB arbiter.
package ahb_arb_pkg;

  localparam int MST_IDX_W  = 4;
  localparam int BEAT_CNT_W = 5;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ST_ARB   = 2'b00,
    ST_BURST = 2'b01,
    ST_LOCK  = 2'b10
  } arb_state_e;

  // Number of beats in a fixed-length burst; 0 for SINGLE and undefined-length INCR.
  function automatic logic [BEAT_CNT_W-1:0] burst_len(input logic [2:0] hburst);
    case (hburst_e'(hburst))
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin pick: the first requester found searching ptr+1, ptr+2, ...
// modulo P_NUMM, so the master at ptr itself is considered last.
module ahb_rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int P_NUMM = 3
) (
  input  logic [P_NUMM-1:0]    req,
  input  logic [MST_IDX_W-1:0] ptr,
  output logic [MST_IDX_W-1:0] win_idx,
  output logic                 win_valid
);

  int best_dist;

  // Distance of idx from the slot just after base, wrapping at P_NUMM.
  function automatic int rr_dist(input int idx, input int base);
    if (idx > base) return idx - base - 1;
    else            return idx - base - 1 + P_NUMM;
  endfunction

  // Keep the requester with the smallest rotated distance from the pointer.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    best_dist = P_NUMM;
    for (int i = 0; i < P_NUMM; i++) begin
      if (req[i] && (rr_dist(i, int'(ptr)) < best_dist)) begin
        best_dist = rr_dist(i, int'(ptr));
        win_idx   = MST_IDX_W'(i);
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB arbiter with burst and lock protection.
// Optional feature: define AHB_ARB_SPLIT_EN to mask SPLIT-responded masters
// until their slave raises the matching HSPLIT bit; without it SPLIT acts as RETRY.
module ahb_arbiter_rr
  import ahb_arb_pkg::*;
#(
  parameter int P_NUMM        = 3,
  parameter int P_DEFAULT_MST = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [P_NUMM-1:0]    HBUSREQ,
  input  logic [P_NUMM-1:0]    HLOCK,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HBURST,
  input  logic                 HREADY,
  input  logic [1:0]           HRESP,
  input  logic [15:0]          HSPLIT,
  output logic [P_NUMM-1:0]    HGRANT,
  output logic [MST_IDX_W-1:0] HMASTER,
  output logic                 HMASTLOCK
);

  localparam logic [P_NUMM-1:0]    GNT_ONE = P_NUMM'(1);
  localparam logic [MST_IDX_W-1:0] DEF_IDX = MST_IDX_W'(P_DEFAULT_MST);

  arb_state_e              state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0]   beat_len;
  logic [MST_IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                    err_arb_q, err_arb_d;
  logic [P_NUMM-1:0]       hgrant_d;
  logic [MST_IDX_W-1:0]    hmaster_d;
  logic                    hmastlock_d;
  logic [P_NUMM-1:0]       split_mask;
  logic [P_NUMM-1:0]       cand;
  logic [MST_IDX_W-1:0]    pick_idx;
  logic                    pick_valid;
  logic [MST_IDX_W-1:0]    win_idx;
  logic                    lock_gnt;
  logic                    err_resp;
  logic                    arb_edge;
  logic                    unused_hsplit;

  assign unused_hsplit = ^HSPLIT;

  assign beat_len = burst_len(HBURST);
  assign lock_gnt = |(HLOCK & HGRANT);
  assign err_resp = !HREADY && (HRESP != HRESP_OKAY);
  assign cand     = HBUSREQ & ~split_mask;
  assign win_idx  = pick_valid ? pick_idx : DEF_IDX;

  ahb_rr_pick #(
    .P_NUMM (P_NUMM)
  ) u_pick (
    .req       (cand),
    .ptr       (rr_ptr_q),
    .win_idx   (pick_idx),
    .win_valid (pick_valid)
  );

`ifdef AHB_ARB_SPLIT_EN
  // Park a master on the first SPLIT cycle; a release and a new SPLIT together leave it parked.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      split_mask <= '0;
    else
      split_mask <= (split_mask & ~HSPLIT[P_NUMM-1:0]) |
                    ((!HREADY && (HRESP == HRESP_SPLIT)) ? (GNT_ONE << HMASTER) : '0);
  end
`else
  assign split_mask = '0;
`endif

  // Next-state, beat counter, arbitration and ownership handover.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    err_arb_d   = err_arb_q;
    hgrant_d    = HGRANT;
    hmaster_d   = HMASTER;
    hmastlock_d = HMASTLOCK;
    arb_edge    = 1'b0;

    if (err_resp) begin
      beat_cnt_d = '0;
      state_d    = ST_ARB;
      err_arb_d  = 1'b1;
    end else if (HREADY) begin
      err_arb_d   = 1'b0;
      hmaster_d   = rr_ptr_q;
      hmastlock_d = lock_gnt;

      if (HTRANS == HTRANS_NONSEQ)
        beat_cnt_d = (beat_len == '0) ? '0 : beat_len - 5'd1;
      else if ((HTRANS == HTRANS_SEQ) && (beat_cnt_q != '0))
        beat_cnt_d = beat_cnt_q - 5'd1;

      case (state_q)
        ST_ARB: begin
          if (err_arb_q)
            arb_edge = 1'b1;
          else if ((HTRANS == HTRANS_NONSEQ) && (beat_len != '0))
            state_d = ST_BURST;
          else if (lock_gnt)
            state_d = ST_LOCK;
          else
            arb_edge = 1'b1;
        end
        ST_BURST: begin
          if ((HTRANS == HTRANS_SEQ) && (beat_cnt_q == 5'd1)) begin
            arb_edge = 1'b1;
            state_d  = ST_ARB;
          end
        end
        ST_LOCK: begin
          if (!lock_gnt) begin
            arb_edge = 1'b1;
            state_d  = ST_ARB;
          end
        end
        default: state_d = ST_ARB;
      endcase

      if (arb_edge) begin
        rr_ptr_d = win_idx;
        hgrant_d = GNT_ONE << win_idx;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_ARB;
      beat_cnt_q <= '0;
      rr_ptr_q   <= DEF_IDX;
      err_arb_q  <= 1'b0;
      HGRANT     <= GNT_ONE << DEF_IDX;
      HMASTER    <= DEF_IDX;
      HMASTLOCK  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      err_arb_q  <= err_arb_d;
      HGRANT     <= hgrant_d;
      HMASTER    <= hmaster_d;
      HMASTLOCK  <= hmastlock_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr (3 masters, default master 0).
// Covers reset, round-robin, fixed burst, locked sequence, SPLIT/RETRY,
// idle default grant, HREADY stalls, error abort and reset mid-burst.
module tb_ahb_arbiter_rr;
  import ahb_arb_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic [2:0]  HBUSREQ;
  logic [2:0]  HLOCK;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [15:0] HSPLIT;
  logic [2:0]  HGRANT;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;

  int checks_total  = 0;
  int checks_passed = 0;

`ifdef AHB_ARB_SPLIT_EN
  localparam logic [31:0] EXP_PARKED_GNT = 32'h1;
`else
  localparam logic [31:0] EXP_PARKED_GNT = 32'h4;
`endif

  ahb_arbiter_rr #(
    .P_NUMM        (3),
    .P_DEFAULT_MST (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HSPLIT    (HSPLIT),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic [2:0] lck,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic rdy, input logic [1:0] rsp,
                               input logic [15:0] spl);
    HBUSREQ = req;
    HLOCK   = lck;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = rdy;
    HRESP   = rsp;
    HSPLIT  = spl;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    HBUSREQ = '0; HLOCK = '0; HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
    HREADY = 1'b1; HRESP = HRESP_OKAY; HSPLIT = '0;
    @(negedge HCLK);

    // Reset wins over pending requests.
    applyStimulus(3'b111, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("rst_gnt",  32'(HGRANT), 32'h1);
    checkOutput("rst_mst",  32'(HMASTER), 32'h0);
    checkOutput("rst_lock", 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;

    // Masters 0 and 2 request with pointer 0: master 2 wins first.
    applyStimulus(3'b101, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("rr_gnt_m2", 32'(HGRANT), 32'h4);
    checkOutput("rr_mst_m0", 32'(HMASTER), 32'h0);
    applyStimulus(3'b001, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("rr_gnt_m0", 32'(HGRANT), 32'h1);
    checkOutput("rr_mst_m2", 32'(HMASTER), 32'h2);
    applyStimulus(3'b001, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("rr_mst_back", 32'(HMASTER), 32'h0);

    // Master 1 INCR8 with master 0 requesting throughout, one wait state inside.
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("burst_gnt_m1", 32'(HGRANT), 32'h2);
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("burst_mst_m1", 32'(HMASTER), 32'h1);
    applyStimulus(3'b011, 3'b000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("burst_beat1_gnt", 32'(HGRANT), 32'h2);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        applyStimulus(3'b011, 3'b000, HTRANS_SEQ, HBURST_INCR8, 1'b0, HRESP_OKAY, 16'h0);
        checkOutput("burst_wait_gnt", 32'(HGRANT), 32'h2);
      end
      applyStimulus(3'b011, 3'b000, HTRANS_SEQ, HBURST_INCR8, 1'b1, HRESP_OKAY, 16'h0);
      checkOutput("burst_seq_gnt", 32'(HGRANT), (i == 6) ? 32'h1 : 32'h2);
    end
    checkOutput("burst_end_mst", 32'(HMASTER), 32'h1);

    // Master 0 locked across three SINGLE transfers while master 1 requests.
    applyStimulus(3'b011, 3'b001, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("lock_gnt",  32'(HGRANT), 32'h1);
    checkOutput("lock_mst",  32'(HMASTER), 32'h0);
    checkOutput("lock_flag", 32'(HMASTLOCK), 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b011, 3'b001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
      checkOutput("lock_hold_gnt",  32'(HGRANT), 32'h1);
      checkOutput("lock_hold_flag", 32'(HMASTLOCK), 32'h1);
    end
    applyStimulus(3'b011, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("unlock_gnt",  32'(HGRANT), 32'h2);
    checkOutput("unlock_flag", 32'(HMASTLOCK), 32'h0);

    // Slave answers master 2 with SPLIT; parked until HSPLIT[2] when the feature is built.
    applyStimulus(3'b100, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("split_gnt_m2", 32'(HGRANT), 32'h4);
    applyStimulus(3'b100, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("split_mst_m2", 32'(HMASTER), 32'h2);
    applyStimulus(3'b100, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    applyStimulus(3'b100, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_SPLIT, 16'h0);
    checkOutput("split_cyc1_gnt", 32'(HGRANT), 32'h4);
    applyStimulus(3'b100, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_SPLIT, 16'h0);
    checkOutput("split_cyc2_gnt", 32'(HGRANT), EXP_PARKED_GNT);
    applyStimulus(3'b100, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("split_parked_gnt", 32'(HGRANT), EXP_PARKED_GNT);
    applyStimulus(3'b100, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0004);
    checkOutput("split_release_gnt", 32'(HGRANT), EXP_PARKED_GNT);
    applyStimulus(3'b100, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("split_rewin_gnt", 32'(HGRANT), 32'h4);

    // Nobody requests: default master; then a 5-cycle stall hides a request change.
    applyStimulus(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("idle_gnt", 32'(HGRANT), 32'h1);
    applyStimulus(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("idle_mst", 32'(HMASTER), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b010, 3'b001, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_OKAY, 16'h0);
      checkOutput("stall_gnt",  32'(HGRANT), 32'h1);
      checkOutput("stall_mst",  32'(HMASTER), 32'h0);
      checkOutput("stall_lock", 32'(HMASTLOCK), 32'h0);
    end
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("stall_end_gnt", 32'(HGRANT), 32'h2);

    // Reset at beat 3 of a WRAP4, then a clean WRAP4 from master 1.
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    applyStimulus(3'b011, 3'b000, HTRANS_NONSEQ, HBURST_WRAP4, 1'b1, HRESP_OKAY, 16'h0);
    applyStimulus(3'b011, 3'b000, HTRANS_SEQ, HBURST_WRAP4, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("wrap_pre_rst_gnt", 32'(HGRANT), 32'h2);
    HRESETn = 1'b0;
    applyStimulus(3'b011, 3'b000, HTRANS_SEQ, HBURST_WRAP4, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("midrst_gnt",  32'(HGRANT), 32'h1);
    checkOutput("midrst_mst",  32'(HMASTER), 32'h0);
    checkOutput("midrst_lock", 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("post_rst_gnt", 32'(HGRANT), 32'h2);
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("post_rst_mst", 32'(HMASTER), 32'h1);
    applyStimulus(3'b011, 3'b000, HTRANS_NONSEQ, HBURST_WRAP4, 1'b1, HRESP_OKAY, 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b011, 3'b000, HTRANS_SEQ, HBURST_WRAP4, 1'b1, HRESP_OKAY, 16'h0);
      checkOutput("wrap_seq_gnt", 32'(HGRANT), (i == 2) ? 32'h1 : 32'h2);
    end

    // ERROR mid-INCR4 aborts the burst; the second response cycle re-arbitrates.
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    applyStimulus(3'b010, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0);
    applyStimulus(3'b011, 3'b000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, HRESP_OKAY, 16'h0);
    applyStimulus(3'b011, 3'b000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY, 16'h0);
    checkOutput("err_burst_gnt", 32'(HGRANT), 32'h2);
    applyStimulus(3'b011, 3'b000, HTRANS_IDLE, HBURST_INCR4, 1'b0, HRESP_ERROR, 16'h0);
    checkOutput("err_cyc1_gnt", 32'(HGRANT), 32'h2);
    applyStimulus(3'b011, 3'b000, HTRANS_IDLE, HBURST_INCR4, 1'b1, HRESP_ERROR, 16'h0);
    checkOutput("err_cyc2_gnt", 32'(HGRANT), 32'h1);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
